// File: rtl/i2c_fifo_access_arb.sv
// Round-robin sharing of the I2C TX-FIFO push and RX-FIFO pop ports.
// Ports: pclk/presetn, ic_enable, tx_req/tx_req_data/tx_gnt, rx_req/rx_gnt/rx_rdata, FIFO side.
module i2c_fifo_access_arb #(
  parameter int NUM_REQ = 2,
  parameter int TX_DW   = 9,
  parameter int RX_DW   = 8
) (
  input  logic                     pclk,
  input  logic                     presetn,
  input  logic                     ic_enable,
  input  logic [NUM_REQ-1:0]       tx_req,
  input  logic [NUM_REQ*TX_DW-1:0] tx_req_data,
  output logic [NUM_REQ-1:0]       tx_gnt,
  input  logic [NUM_REQ-1:0]       rx_req,
  output logic [NUM_REQ-1:0]       rx_gnt,
  output logic [RX_DW-1:0]         rx_rdata,
  input  logic                     tx_full,
  input  logic                     rx_empty,
  input  logic [RX_DW-1:0]         rx_pop_data,
  output logic                     tx_push,
  output logic [TX_DW-1:0]         tx_push_data,
  output logic                     rx_pop
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef logic [IW-1:0] idx_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_PUSH,
    TX_SETTLE
  } tx_st_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_POP,
    RX_SETTLE
  } rx_st_t;

  // Scan downward so the candidate closest above ptr is written last.
  function automatic idx_t rr_pick(
    input logic [NUM_REQ-1:0] req,
    input idx_t               ptr
  );
    idx_t pick;
    int   i;
    pick = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      i = (int'(ptr) + k) % NUM_REQ;
      if (req[i]) pick = idx_t'(i);
    end
    return pick;
  endfunction

  function automatic idx_t rr_next(input idx_t w);
    return idx_t'((int'(w) + 1) % NUM_REQ);
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input idx_t w);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[w] = 1'b1;
    return v;
  endfunction

  tx_st_t           tx_st;
  rx_st_t           rx_st;
  idx_t             tx_ptr;
  idx_t             rx_ptr;
  idx_t             tx_win;
  idx_t             rx_win;
  logic [TX_DW-1:0] tx_sel;
  logic             tx_start;
  logic             rx_start;

  always_comb begin
    tx_win   = rr_pick(tx_req, tx_ptr);
    rx_win   = rr_pick(rx_req, rx_ptr);
    tx_sel   = tx_req_data[tx_win*TX_DW +: TX_DW];
    tx_start = ic_enable & ~tx_full & (|tx_req);
    rx_start = ic_enable & ~rx_empty & (|rx_req);
  end

  // Strobes are registered on entry to PUSH; SETTLE lets tx_full catch up.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      tx_st        <= TX_IDLE;
      tx_ptr       <= '0;
      tx_push      <= 1'b0;
      tx_gnt       <= '0;
      tx_push_data <= '0;
    end else begin
      unique case (tx_st)
        TX_IDLE: begin
          if (tx_start) begin
            tx_st        <= TX_PUSH;
            tx_push      <= 1'b1;
            tx_gnt       <= onehot(tx_win);
            tx_push_data <= tx_sel;
            tx_ptr       <= rr_next(tx_win);
          end
        end
        TX_PUSH: begin
          tx_st   <= TX_SETTLE;
          tx_push <= 1'b0;
          tx_gnt  <= '0;
        end
        TX_SETTLE: begin
          tx_st <= TX_IDLE;
        end
        default: begin
          tx_st   <= TX_IDLE;
          tx_push <= 1'b0;
          tx_gnt  <= '0;
        end
      endcase
    end
  end

  // rx_rdata captures the head before the pop and holds until the next one.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      rx_st    <= RX_IDLE;
      rx_ptr   <= '0;
      rx_pop   <= 1'b0;
      rx_gnt   <= '0;
      rx_rdata <= '0;
    end else begin
      unique case (rx_st)
        RX_IDLE: begin
          if (rx_start) begin
            rx_st    <= RX_POP;
            rx_pop   <= 1'b1;
            rx_gnt   <= onehot(rx_win);
            rx_rdata <= rx_pop_data;
            rx_ptr   <= rr_next(rx_win);
          end
        end
        RX_POP: begin
          rx_st  <= RX_SETTLE;
          rx_pop <= 1'b0;
          rx_gnt <= '0;
        end
        RX_SETTLE: begin
          rx_st <= RX_IDLE;
        end
        default: begin
          rx_st  <= RX_IDLE;
          rx_pop <= 1'b0;
          rx_gnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_fifo_access_arb.sv
// Bench for i2c_fifo_access_arb: directed steps then a random run
// against a transaction-level round-robin model.
module tb_i2c_fifo_access_arb;

  localparam int N  = 2;
  localparam int TW = 9;
  localparam int RW = 8;

  logic          pclk = 1'b0;
  logic          presetn;
  logic          ic_enable;
  logic [N-1:0]  tx_req;
  logic [N*TW-1:0] tx_req_data;
  logic [N-1:0]  tx_gnt;
  logic [N-1:0]  rx_req;
  logic [N-1:0]  rx_gnt;
  logic [RW-1:0] rx_rdata;
  logic          tx_full;
  logic          rx_empty;
  logic [RW-1:0] rx_pop_data;
  logic          tx_push;
  logic [TW-1:0] tx_push_data;
  logic          rx_pop;

  i2c_fifo_access_arb #(.NUM_REQ(N), .TX_DW(TW), .RX_DW(RW)) dut (
    .pclk        (pclk),
    .presetn     (presetn),
    .ic_enable   (ic_enable),
    .tx_req      (tx_req),
    .tx_req_data (tx_req_data),
    .tx_gnt      (tx_gnt),
    .rx_req      (rx_req),
    .rx_gnt      (rx_gnt),
    .rx_rdata    (rx_rdata),
    .tx_full     (tx_full),
    .rx_empty    (rx_empty),
    .rx_pop_data (rx_pop_data),
    .tx_push     (tx_push),
    .tx_push_data(tx_push_data),
    .rx_pop      (rx_pop)
  );

  always #5 pclk = ~pclk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge pclk);
  endtask

  task automatic idle_all();
    tx_req = '0;
    rx_req = '0;
    tx_req_data = '0;
    repeat (4) step();
  endtask

  // model state for the random phase
  logic [TW-1:0] txq[N][$];
  int            rxc[N];
  int            tx_ptr_m, rx_ptr_m, tx_last, rx_last;
  logic [RW-1:0] rdata_m;

  initial begin : main
    logic [TW-1:0] seen[$];
    logic [TW-1:0] fq0[2];
    logic [TW-1:0] fq1[2];
    int i0, i1, w, k, c;
    bit any, pushed, ok;

    presetn = 1'b0;
    ic_enable = 1'b1;
    tx_req = '0;
    rx_req = '0;
    tx_req_data = '0;
    tx_full = 1'b0;
    rx_empty = 1'b1;
    rx_pop_data = '0;

    // reset values
    repeat (2) step();
    chk("rst_tx_push", tx_push, 0);
    chk("rst_tx_gnt", tx_gnt, 0);
    chk("rst_tx_data", tx_push_data, 0);
    chk("rst_rx_pop", rx_pop, 0);
    chk("rst_rx_gnt", rx_gnt, 0);
    chk("rst_rx_rdata", rx_rdata, 0);
    presetn = 1'b1;
    step();

    // fairness: both requesters hold two entries each
    fq0[0] = 9'h011; fq0[1] = 9'h012;
    fq1[0] = 9'h021; fq1[1] = 9'h022;
    i0 = 0; i1 = 0;
    tx_req = 2'b11;
    tx_req_data = {fq1[0], fq0[0]};
    for (int t = 0; t < 30 && seen.size() < 4; t++) begin
      step();
      if (tx_push) begin
        seen.push_back(tx_push_data);
        if (tx_gnt[0]) i0++;
        if (tx_gnt[1]) i1++;
        tx_req[0] = (i0 < 2);
        tx_req[1] = (i1 < 2);
        tx_req_data = {fq1[i1 > 1 ? 1 : i1], fq0[i0 > 1 ? 1 : i0]};
      end
    end
    chk("fair_count", seen.size(), 4);
    while (seen.size() < 4) seen.push_back('1);
    chk("fair_0", seen[0], 9'h011);
    chk("fair_1", seen[1], 9'h021);
    chk("fair_2", seen[2], 9'h012);
    chk("fair_3", seen[3], 9'h022);
    idle_all();

    // single push and minimum spacing
    tx_req = 2'b01;
    tx_req_data = {9'h000, 9'h0A5};
    step();
    chk("single_push", tx_push, 1);
    chk("single_gnt", tx_gnt, 2'b01);
    chk("single_data", tx_push_data, 9'h0A5);
    tx_req_data = {9'h000, 9'h0B6};
    step();
    chk("space_1", tx_push, 0);
    step();
    chk("space_2", tx_push, 0);
    step();
    chk("space_3", tx_push, 1);
    chk("space_3_data", tx_push_data, 9'h0B6);
    idle_all();

    // backpressure
    tx_full = 1'b1;
    tx_req = 2'b01;
    tx_req_data = {9'h000, 9'h1C3};
    pushed = 1'b0;
    repeat (10) begin
      step();
      if (tx_push || tx_gnt != 0) pushed = 1'b1;
    end
    chk("bp_no_push", pushed, 0);
    tx_full = 1'b0;
    step();
    chk("bp_push", tx_push, 1);
    chk("bp_gnt", tx_gnt, 2'b01);
    chk("bp_data", tx_push_data, 9'h1C3);
    idle_all();

    // rx pop and hold
    rx_empty = 1'b0;
    rx_pop_data = 8'h5C;
    rx_req = 2'b10;
    step();
    chk("rx_pop", rx_pop, 1);
    chk("rx_gnt", rx_gnt, 2'b10);
    chk("rx_rdata", rx_rdata, 8'h5C);
    rx_req = '0;
    rx_pop_data = 8'h77;
    step();
    chk("rx_pop_end", rx_pop, 0);
    step();
    chk("rx_hold", rx_rdata, 8'h5C);
    rx_empty = 1'b1;
    rx_req = 2'b01;
    pushed = 1'b0;
    repeat (5) begin
      step();
      if (rx_pop || rx_gnt != 0) pushed = 1'b1;
    end
    chk("rx_empty_no_pop", pushed, 0);
    idle_all();

    // concurrency and enable drop during push
    rx_empty = 1'b0;
    rx_pop_data = 8'h3E;
    tx_req = 2'b01;
    tx_req_data = {9'h000, 9'h055};
    rx_req = 2'b01;
    step();
    chk("conc_tx", tx_push, 1);
    chk("conc_rx", rx_pop, 1);
    chk("conc_data", tx_push_data, 9'h055);
    ic_enable = 1'b0;
    tx_req_data = {9'h000, 9'h056};
    pushed = 1'b0;
    repeat (6) begin
      step();
      if (tx_push || rx_pop || tx_gnt != 0 || rx_gnt != 0) pushed = 1'b1;
    end
    chk("dis_no_grant", pushed, 0);
    ic_enable = 1'b1;
    step();
    chk("en_resume", tx_push, 1);
    idle_all();
    rx_empty = 1'b1;

    // reset during PUSH, then pointer back at requester 0
    tx_req = 2'b01;
    tx_req_data = {9'h000, 9'h1FF};
    step();
    chk("rstp_push", tx_push, 1);
    presetn = 1'b0;
    #1;
    chk("rstp_tx_push", tx_push, 0);
    chk("rstp_tx_gnt", tx_gnt, 0);
    chk("rstp_tx_data", tx_push_data, 0);
    tx_req = '0;
    step();
    presetn = 1'b1;
    tx_req = 2'b11;
    tx_req_data = {9'h111, 9'h100};
    step();
    chk("rstp_first_gnt", tx_gnt, 2'b01);
    chk("rstp_first_data", tx_push_data, 9'h100);
    tx_req = '0;

    // random phase
    presetn = 1'b0;
    step();
    presetn = 1'b1;
    tx_ptr_m = 0; rx_ptr_m = 0;
    tx_last = -10; rx_last = -10;
    rdata_m = '0;
    for (int i = 0; i < N; i++) begin
      txq[i].delete();
      rxc[i] = 0;
    end
    for (c = 0; c < 3000; c++) begin
      step();
      // TX expectation from the inputs the last edge sampled
      any = 1'b0;
      for (int i = 0; i < N; i++) if (txq[i].size() > 0) any = 1'b1;
      if ((c - tx_last >= 3) && ic_enable && !tx_full && any) begin
        w = -1;
        for (k = 0; k < N; k++)
          if (w < 0 && txq[(tx_ptr_m + k) % N].size() > 0)
            w = (tx_ptr_m + k) % N;
        chk("r_tx_push", tx_push, 1);
        chk("r_tx_gnt", tx_gnt, 32'(1) << w);
        chk("r_tx_data", tx_push_data, txq[w][0]);
        void'(txq[w].pop_front());
        tx_ptr_m = (w + 1) % N;
        tx_last = c;
      end else begin
        chk("r_tx_idle", {tx_push, tx_gnt}, 0);
      end
      // RX expectation
      any = 1'b0;
      for (int i = 0; i < N; i++) if (rxc[i] > 0) any = 1'b1;
      if ((c - rx_last >= 3) && ic_enable && !rx_empty && any) begin
        w = -1;
        for (k = 0; k < N; k++)
          if (w < 0 && rxc[(rx_ptr_m + k) % N] > 0)
            w = (rx_ptr_m + k) % N;
        chk("r_rx_pop", rx_pop, 1);
        chk("r_rx_gnt", rx_gnt, 32'(1) << w);
        rdata_m = rx_pop_data;
        rxc[w]--;
        rx_ptr_m = (w + 1) % N;
        rx_last = c;
      end else begin
        chk("r_rx_idle", {rx_pop, rx_gnt}, 0);
      end
      chk("r_rx_rdata", rx_rdata, rdata_m);
      // new work and new FIFO conditions
      for (int i = 0; i < N; i++) begin
        if (txq[i].size() < 3 && $urandom_range(3) == 0)
          txq[i].push_back(TW'($urandom));
        if (rxc[i] < 3 && $urandom_range(3) == 0)
          rxc[i]++;
        tx_req[i] = (txq[i].size() > 0);
        tx_req_data[i*TW +: TW] = (txq[i].size() > 0) ? txq[i][0] : '0;
        rx_req[i] = (rxc[i] > 0);
      end
      tx_full = ($urandom_range(3) == 0);
      rx_empty = ($urandom_range(2) == 0);
      ic_enable = ($urandom_range(7) != 0);
      rx_pop_data = RW'($urandom);
    end

    ok = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
